// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// FetchQueue (module fetch_queue)
//
// Purpose:
//   Small circular FIFO sitting between the fetch stage (PC register and
//   instruction memory) and the decode stage. Each fetched word is stored
//   together with its PC and PC+4. The oldest entry is presented to decode.
//   When the queue is full, it stalls the PC register.
//   A flush (branch/jump redirect) throws away everything queued plus any
//   word arriving in the same cycle.
//
// Ports:
//   clk         in   rising-edge clock
//   reset       in   asynchronous active-low reset (0 = reset asserted)
//   push_valid  in   fetched word valid this cycle
//   instr_f     in   fetched instruction word
//   pc_f        in   PC of the fetched word
//   flush       in   redirect: discard all queued and incoming entries
//   pop_ready   in   decode consumes the head this cycle
//   stall_f     out  queue full; holds the PC register
//   valid_d     out  head entry valid
//   instr_d     out  head instruction, NOP (addi x0,x0,0) when empty
//   pc_d        out  head PC, 0 when empty
//   pcplus4_d   out  head PC+4, 0 when empty
//   count       out  current occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module fetch_queue #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 4,
    localparam int PTRW  = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_valid,
    input  logic [WIDTH-1:0] instr_f,
    input  logic [WIDTH-1:0] pc_f,
    input  logic             flush,
    input  logic             pop_ready,
    output logic             stall_f,
    output logic             valid_d,
    output logic [WIDTH-1:0] instr_d,
    output logic [WIDTH-1:0] pc_d,
    output logic [WIDTH-1:0] pcplus4_d,
    output logic [PTRW:0]    count
);

    localparam logic [PTRW:0]    FULL_COUNT = (PTRW+1)'(DEPTH);
    localparam logic [PTRW:0]    COUNT_ONE  = (PTRW+1)'(1);
    localparam logic [PTRW-1:0]  PTR_ONE    = PTRW'(1);
    localparam logic [WIDTH-1:0] NOP_INSTR  = WIDTH'(32'h0000_0013);
    localparam logic [WIDTH-1:0] PC_STEP    = WIDTH'(4);

    logic [WIDTH-1:0] r_instr [DEPTH];
    logic [WIDTH-1:0] r_pc    [DEPTH];
    logic [WIDTH-1:0] r_pc4   [DEPTH];

    logic [PTRW-1:0]  r_wr_ptr;
    logic [PTRW-1:0]  r_rd_ptr;
    logic [PTRW:0]    r_count;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;

    assign w_full  = (r_count == FULL_COUNT);
    assign w_empty = (r_count == '0);

    // A pop frees a slot in the same cycle, so a full queue can still accept a
    // push when decode is draining it. Flush overrides both operations.
    assign w_pop  = pop_ready & ~w_empty & ~flush;
    assign w_push = push_valid & ~flush & (~w_full | w_pop);

    // Entry storage needs no reset. Stale slots are never visible, because
    // the head mux below is gated by occupancy.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_instr[r_wr_ptr] <= instr_f;
            r_pc[r_wr_ptr]    <= pc_f;
            r_pc4[r_wr_ptr]   <= pc_f + PC_STEP;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    // Flush returns the queue to its reset shape, so the next word lands in
    // slot 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + COUNT_ONE;
                2'b01:   r_count <= r_count - COUNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Outputs depend only on registered state. Decode sees a harmless NOP
    // with zero PCs whenever nothing is queued.
    always_comb begin
        valid_d   = ~w_empty;
        stall_f   = w_full;
        count     = r_count;
        instr_d   = NOP_INSTR;
        pc_d      = '0;
        pcplus4_d = '0;
        if (!w_empty) begin
            instr_d   = r_instr[r_rd_ptr];
            pc_d      = r_pc[r_rd_ptr];
            pcplus4_d = r_pc4[r_rd_ptr];
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_fetch_queue
//
// Purpose:
//   Directed bench for fetch_queue. Each scenario task drives its own
//   stimulus and checks against hand-computed values.
//   Inputs change just after a rising edge, and outputs are examined
//   there too, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_fetch_queue;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;

    logic              clk;
    logic              reset;
    logic              push_valid;
    logic [WIDTH-1:0]  instr_f;
    logic [WIDTH-1:0]  pc_f;
    logic              flush;
    logic              pop_ready;
    logic              stall_f;
    logic              valid_d;
    logic [WIDTH-1:0]  instr_d;
    logic [WIDTH-1:0]  pc_d;
    logic [WIDTH-1:0]  pcplus4_d;
    logic [2:0]        count;

    int total;
    int bad;

    fetch_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .push_valid (push_valid),
        .instr_f    (instr_f),
        .pc_f       (pc_f),
        .flush      (flush),
        .pop_ready  (pop_ready),
        .stall_f    (stall_f),
        .valid_d    (valid_d),
        .instr_d    (instr_d),
        .pc_d       (pc_d),
        .pcplus4_d  (pcplus4_d),
        .count      (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one cycle of inputs, let the rising edge take them, then go idle.
    task automatic applyStimulus(input logic pv, input logic [31:0] ins,
                                 input logic [31:0] pc, input logic fl,
                                 input logic pr);
        push_valid = pv;
        instr_f    = ins;
        pc_f       = pc;
        flush      = fl;
        pop_ready  = pr;
        @(posedge clk);
        #1;
        push_valid = 1'b0;
        flush      = 1'b0;
        pop_ready  = 1'b0;
    endtask

    task automatic applyReset();
        push_valid = 1'b0;
        flush      = 1'b0;
        pop_ready  = 1'b0;
        instr_f    = '0;
        pc_f       = '0;
        reset      = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        applyReset();
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        total++; if (valid_d !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%0b want=0", valid_d); end
        total++; if (instr_d !== 32'h13) begin bad++; $display("[TB] FAIL reset_instr got=%h want=00000013", instr_d); end
        total++; if (pc_d !== 32'h0) begin bad++; $display("[TB] FAIL reset_pc got=%h want=0", pc_d); end
        total++; if (pcplus4_d !== 32'h0) begin bad++; $display("[TB] FAIL reset_pc4 got=%h want=0", pcplus4_d); end
        total++; if (stall_f !== 1'b0) begin bad++; $display("[TB] FAIL reset_stall got=%0b want=0", stall_f); end
        total++; if (count !== 3'd0) begin bad++; $display("[TB] FAIL reset_count got=%0d want=0", count); end
    endtask

    task automatic test_async_reset();
        applyReset();
        applyStimulus(1'b1, 32'hD0, 32'h40, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'hD1, 32'h44, 1'b0, 1'b0);
        total++; if (count !== 3'd2) begin bad++; $display("[TB] FAIL async_pre_count got=%0d want=2", count); end
        // Drop reset between edges and look before any further edge arrives.
        #2;
        reset = 1'b0;
        #1;
        total++; if (count !== 3'd0) begin bad++; $display("[TB] FAIL async_count got=%0d want=0", count); end
        total++; if (valid_d !== 1'b0) begin bad++; $display("[TB] FAIL async_valid got=%0b want=0", valid_d); end
        total++; if (instr_d !== 32'h13) begin bad++; $display("[TB] FAIL async_instr got=%h want=00000013", instr_d); end
        total++; if (pc_d !== 32'h0) begin bad++; $display("[TB] FAIL async_pc got=%h want=0", pc_d); end
        total++; if (pcplus4_d !== 32'h0) begin bad++; $display("[TB] FAIL async_pc4 got=%h want=0", pcplus4_d); end
        total++; if (stall_f !== 1'b0) begin bad++; $display("[TB] FAIL async_stall got=%0b want=0", stall_f); end
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_fill_and_overflow();
        applyReset();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 32'hA0 + i, 32'h4 * i, 1'b0, 1'b0);
        end
        total++; if (count !== 3'd4) begin bad++; $display("[TB] FAIL fill_count got=%0d want=4", count); end
        total++; if (stall_f !== 1'b1) begin bad++; $display("[TB] FAIL fill_stall got=%0b want=1", stall_f); end
        total++; if (pc_d !== 32'h0) begin bad++; $display("[TB] FAIL fill_pc got=%h want=0", pc_d); end
        total++; if (pcplus4_d !== 32'h4) begin bad++; $display("[TB] FAIL fill_pc4 got=%h want=4", pcplus4_d); end
        total++; if (instr_d !== 32'hA0) begin bad++; $display("[TB] FAIL fill_instr got=%h want=a0", instr_d); end
        // A fifth word while full and not draining must vanish.
        applyStimulus(1'b1, 32'hEE, 32'h10, 1'b0, 1'b0);
        total++; if (count !== 3'd4) begin bad++; $display("[TB] FAIL overflow_count got=%0d want=4", count); end
        total++; if (pc_d !== 32'h0) begin bad++; $display("[TB] FAIL overflow_pc got=%h want=0", pc_d); end
    endtask

    task automatic test_full_push_pop();
        logic [31:0] expPc [4];
        expPc[0] = 32'h4;
        expPc[1] = 32'h8;
        expPc[2] = 32'hC;
        expPc[3] = 32'h10;
        // Continues from the full queue left by test_fill_and_overflow.
        applyStimulus(1'b1, 32'hA4, 32'h10, 1'b0, 1'b1);
        total++; if (count !== 3'd4) begin bad++; $display("[TB] FAIL fullpp_count got=%0d want=4", count); end
        total++; if (pc_d !== 32'h4) begin bad++; $display("[TB] FAIL fullpp_pc got=%h want=4", pc_d); end
        for (int i = 0; i < 4; i++) begin
            total++; if (pc_d !== expPc[i]) begin bad++; $display("[TB] FAIL drain_pc[%0d] got=%h want=%h", i, pc_d, expPc[i]); end
            total++; if (instr_d !== 32'hA1 + i) begin bad++; $display("[TB] FAIL drain_instr[%0d] got=%h want=%h", i, instr_d, 32'hA1 + i); end
            total++; if (pcplus4_d !== expPc[i] + 32'h4) begin bad++; $display("[TB] FAIL drain_pc4[%0d] got=%h want=%h", i, pcplus4_d, expPc[i] + 32'h4); end
            applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        end
        total++; if (count !== 3'd0) begin bad++; $display("[TB] FAIL drain_count got=%0d want=0", count); end
        total++; if (valid_d !== 1'b0) begin bad++; $display("[TB] FAIL drain_valid got=%0b want=0", valid_d); end
    endtask

    task automatic test_back_to_back();
        applyReset();
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 32'hB0 + i, 32'h200 + 4 * i, 1'b0, 1'b1);
            total++; if (instr_d !== 32'hB0 + i) begin bad++; $display("[TB] FAIL stream_instr[%0d] got=%h want=%h", i, instr_d, 32'hB0 + i); end
            total++; if (pc_d !== 32'h200 + 4 * i) begin bad++; $display("[TB] FAIL stream_pc[%0d] got=%h want=%h", i, pc_d, 32'h200 + 4 * i); end
            total++; if (count !== 3'd1) begin bad++; $display("[TB] FAIL stream_count[%0d] got=%0d want=1", i, count); end
        end
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        total++; if (count !== 3'd0) begin bad++; $display("[TB] FAIL stream_end_count got=%0d want=0", count); end
    endtask

    task automatic test_flush();
        applyReset();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 32'hC8 + i, 32'h80 + 4 * i, 1'b0, 1'b0);
        end
        total++; if (count !== 3'd3) begin bad++; $display("[TB] FAIL flush_pre_count got=%0d want=3", count); end
        applyStimulus(1'b1, 32'hCF, 32'h50, 1'b1, 1'b1);
        total++; if (count !== 3'd0) begin bad++; $display("[TB] FAIL flush_count got=%0d want=0", count); end
        total++; if (valid_d !== 1'b0) begin bad++; $display("[TB] FAIL flush_valid got=%0b want=0", valid_d); end
        total++; if (instr_d !== 32'h13) begin bad++; $display("[TB] FAIL flush_instr got=%h want=00000013", instr_d); end
        applyStimulus(1'b1, 32'hC0, 32'h100, 1'b0, 1'b0);
        total++; if (count !== 3'd1) begin bad++; $display("[TB] FAIL postflush_count got=%0d want=1", count); end
        total++; if (pc_d !== 32'h100) begin bad++; $display("[TB] FAIL postflush_pc got=%h want=100", pc_d); end
        total++; if (instr_d !== 32'hC0) begin bad++; $display("[TB] FAIL postflush_instr got=%h want=c0", instr_d); end
        total++; if (pcplus4_d !== 32'h104) begin bad++; $display("[TB] FAIL postflush_pc4 got=%h want=104", pcplus4_d); end
    endtask

    task automatic test_pc_wrap_and_underflow();
        applyReset();
        applyStimulus(1'b1, 32'hF0, 32'hFFFF_FFFC, 1'b0, 1'b0);
        total++; if (pc_d !== 32'hFFFF_FFFC) begin bad++; $display("[TB] FAIL wrap_pc got=%h want=fffffffc", pc_d); end
        total++; if (pcplus4_d !== 32'h0) begin bad++; $display("[TB] FAIL wrap_pc4 got=%h want=0", pcplus4_d); end
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        total++; if (count !== 3'd0) begin bad++; $display("[TB] FAIL pop_last_count got=%0d want=0", count); end
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        total++; if (count !== 3'd0) begin bad++; $display("[TB] FAIL underflow_count got=%0d want=0", count); end
        total++; if (valid_d !== 1'b0) begin bad++; $display("[TB] FAIL underflow_valid got=%0b want=0", valid_d); end
        applyStimulus(1'b1, 32'hF1, 32'h300, 1'b0, 1'b0);
        total++; if (count !== 3'd1) begin bad++; $display("[TB] FAIL after_underflow_count got=%0d want=1", count); end
        total++; if (pc_d !== 32'h300) begin bad++; $display("[TB] FAIL after_underflow_pc got=%h want=300", pc_d); end
        total++; if (instr_d !== 32'hF1) begin bad++; $display("[TB] FAIL after_underflow_instr got=%h want=f1", instr_d); end
    endtask

    // Run every scenario in order, then report.
    initial begin
        total      = 0;
        bad        = 0;
        reset      = 1'b0;
        push_valid = 1'b0;
        flush      = 1'b0;
        pop_ready  = 1'b0;
        instr_f    = '0;
        pc_f       = '0;
        test_reset();
        test_async_reset();
        test_fill_and_overflow();
        test_full_push_pop();
        test_back_to_back();
        test_flush();
        test_pc_wrap_and_underflow();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
